// File: rtl/y86_decode_regfile_pkg.sv
// Shared Y86-64 definitions: widths, register IDs and instruction codes.
package y86_pkg;

    localparam int W    = 64;
    localparam int NREG = 15;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Largest legal function code for an icode (unused icodes report 0).
    function automatic logic [3:0] ifun_limit(input logic [3:0] icode);
        case (icode)
            I_CMOVXX, I_JXX: ifun_limit = 4'd6;
            I_OPQ:           ifun_limit = 4'd3;
            default:         ifun_limit = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/y86_decode_regfile_if.sv
// Decode/register-file bundle; master drives instruction and write-back, slave answers.
interface y86_decode_regfile_if;
    import y86_pkg::*;

    logic [7:0]   opcode;
    logic [7:0]   rArB;
    logic [W-1:0] valC;
    logic         reEn;
    logic         wrEn;
    logic [3:0]   registernumber1_write;
    logic [3:0]   registernumber2_write;
    logic [W-1:0] val_write1;
    logic [W-1:0] val_write2;
    logic [3:0]   registernumber1;
    logic [3:0]   registernumber2;
    logic [3:0]   dst_e;
    logic [3:0]   dst_m;
    logic [W-1:0] val_read1;
    logic [W-1:0] val_read2;
    logic         error;
    logic         regerr;

    modport master (
        output opcode, rArB, valC, reEn, wrEn,
        output registernumber1_write, registernumber2_write, val_write1, val_write2,
        input  registernumber1, registernumber2, dst_e, dst_m,
        input  val_read1, val_read2, error, regerr
    );

    modport slave (
        input  opcode, rArB, valC, reEn, wrEn,
        input  registernumber1_write, registernumber2_write, val_write1, val_write2,
        output registernumber1, registernumber2, dst_e, dst_m,
        output val_read1, val_read2, error, regerr
    );

endinterface

// File: rtl/y86_decode_regfile_regfile.sv
// 15 x 64-bit register file: two combinational read ports, two write ports,
// port 2 overrides port 1 when both target the same register.
module y86_regfile
    import y86_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         re_en,
    input  logic         wr_en,
    input  logic [3:0]   rd_id1,
    input  logic [3:0]   rd_id2,
    input  logic [3:0]   wr_id1,
    input  logic [3:0]   wr_id2,
    input  logic [W-1:0] wr_val1,
    input  logic [W-1:0] wr_val2,
    output logic [W-1:0] rd_val1,
    output logic [W-1:0] rd_val2,
    output logic         regerr
);

    logic [W-1:0] regs_reg [NREG];
    logic [3:0]   rd_id  [2];
    logic [W-1:0] rd_val [2];

    assign rd_id[0] = rd_id1;
    assign rd_id[1] = rd_id2;
    assign rd_val1  = rd_val[0];
    assign rd_val2  = rd_val[1];

    // Write-back; the second assignment lets valM win a same-ID conflict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs_reg[i] <= '0;
        end else if (wr_en) begin
            if (wr_id1 != REG_NONE) regs_reg[wr_id1] <= wr_val1;
            if (wr_id2 != REG_NONE) regs_reg[wr_id2] <= wr_val2;
        end
    end

    // Read ports: ID 0xF or a disabled read returns zero; no write bypass.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            assign rd_val[gi] = (re_en && rd_id[gi] != REG_NONE) ? regs_reg[rd_id[gi]] : '0;
        end
    endgenerate

    assign regerr = wr_en && (wr_id1 == wr_id2) && (wr_id1 != REG_NONE);

endmodule

// File: rtl/y86_decode_regfile.sv
// SEQ Y86-64 decode stage: register selection, legality check and register file.
module y86_decode_regfile
    import y86_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    y86_decode_regfile_if.slave bus
);

    logic [3:0] icode, ifun, ra, rb;
    logic [3:0] src_a, src_b, dst_e, dst_m;
    logic       uses_ra, uses_rb, bad_icode, ra_must_none;

    assign icode = bus.opcode[7:4];
    assign ifun  = bus.opcode[3:0];
    assign ra    = bus.rArB[7:4];
    assign rb    = bus.rArB[3:0];

    // Pick sources/destinations per icode and note which specifier fields are used.
    always_comb begin
        src_a        = REG_NONE;
        src_b        = REG_NONE;
        dst_e        = REG_NONE;
        dst_m        = REG_NONE;
        uses_ra      = 1'b0;
        uses_rb      = 1'b0;
        bad_icode    = 1'b0;
        ra_must_none = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_JXX: ;
            I_CMOVXX: begin src_a = ra; dst_e = rb; uses_ra = 1'b1; uses_rb = 1'b1; end
            I_IRMOVQ: begin dst_e = rb; uses_rb = 1'b1; ra_must_none = 1'b1; end
            I_RMMOVQ: begin src_a = ra; src_b = rb; uses_ra = 1'b1; uses_rb = 1'b1; end
            I_MRMOVQ: begin src_b = rb; dst_m = ra; uses_ra = 1'b1; uses_rb = 1'b1; end
            I_OPQ:    begin src_a = ra; src_b = rb; dst_e = rb; uses_ra = 1'b1; uses_rb = 1'b1; end
            I_CALL:   begin src_b = REG_RSP; dst_e = REG_RSP; end
            I_RET:    begin src_a = REG_RSP; src_b = REG_RSP; dst_e = REG_RSP; end
            I_PUSHQ:  begin src_a = ra; src_b = REG_RSP; dst_e = REG_RSP; uses_ra = 1'b1; end
            I_POPQ:   begin src_a = REG_RSP; src_b = REG_RSP; dst_e = REG_RSP; dst_m = ra; uses_ra = 1'b1; end
            default:  bad_icode = 1'b1;
        endcase
    end

    // Decoded values are still presented on error; later stages gate on the flag.
    assign bus.error = bad_icode
                     || (ifun > ifun_limit(icode))
                     || (uses_ra && ra == REG_NONE)
                     || (uses_rb && rb == REG_NONE)
                     || (ra_must_none && ra != REG_NONE);

    assign bus.registernumber1 = src_a;
    assign bus.registernumber2 = src_b;
    assign bus.dst_e           = dst_e;
    assign bus.dst_m           = dst_m;

    y86_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .re_en   (bus.reEn),
        .wr_en   (bus.wrEn),
        .rd_id1  (src_a),
        .rd_id2  (src_b),
        .wr_id1  (bus.registernumber1_write),
        .wr_id2  (bus.registernumber2_write),
        .wr_val1 (bus.val_write1),
        .wr_val2 (bus.val_write2),
        .rd_val1 (bus.val_read1),
        .rd_val2 (bus.val_read2),
        .regerr  (bus.regerr)
    );

endmodule

// File: tb/tb_y86_decode_regfile.sv
// Directed and random checks of y86_decode_regfile against a table-driven model.
module tb_y86_decode_regfile;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    y86_decode_regfile_if bus ();

    y86_decode_regfile dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Model: per-icode selection tables (0 none, 1 rA, 2 rB, 3 RSP).
    int sa_sel  [16] = '{0,0,1,0,1,0,1,0,0,3,1,3,0,0,0,0};
    int sb_sel  [16] = '{0,0,0,0,2,2,2,0,3,3,3,3,0,0,0,0};
    int de_sel  [16] = '{0,0,2,2,0,0,2,0,3,3,3,3,0,0,0,0};
    int dm_sel  [16] = '{0,0,0,0,0,1,0,0,0,0,0,1,0,0,0,0};
    int fn_max  [16] = '{0,0,6,0,0,0,3,6,0,0,0,0,-1,-1,-1,-1};
    int use_a   [16] = '{0,0,1,0,1,1,1,0,0,0,1,1,0,0,0,0};
    int use_b   [16] = '{0,0,1,1,1,1,1,0,0,0,0,0,0,0,0,0};
    logic [63:0] mregs [16];

    function automatic logic [3:0] pick(input int s, input logic [3:0] ra, input logic [3:0] rb);
        case (s)
            1:       return ra;
            2:       return rb;
            3:       return 4'h4;
            default: return 4'hF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model for the inputs currently applied.
    task automatic check_all(input string tag);
        int ic, fn;
        logic [3:0] ra, rb, sa, sb;
        logic err, rerr;
        ic = int'(bus.opcode[7:4]);
        fn = int'(bus.opcode[3:0]);
        ra = bus.rArB[7:4];
        rb = bus.rArB[3:0];
        sa = pick(sa_sel[ic], ra, rb);
        sb = pick(sb_sel[ic], ra, rb);
        err = (fn > fn_max[ic]) || (use_a[ic] == 1 && ra == 4'hF) ||
              (use_b[ic] == 1 && rb == 4'hF) || (ic == 3 && ra != 4'hF);
        rerr = bus.wrEn && bus.registernumber1_write == bus.registernumber2_write &&
               bus.registernumber1_write != 4'hF;
        chk({tag, ".srcA"},  64'(bus.registernumber1), 64'(sa));
        chk({tag, ".srcB"},  64'(bus.registernumber2), 64'(sb));
        chk({tag, ".dstE"},  64'(bus.dst_e), 64'(pick(de_sel[ic], ra, rb)));
        chk({tag, ".dstM"},  64'(bus.dst_m), 64'(pick(dm_sel[ic], ra, rb)));
        chk({tag, ".error"}, 64'(bus.error), 64'(err));
        chk({tag, ".regerr"}, 64'(bus.regerr), 64'(rerr));
        chk({tag, ".valA"},  bus.val_read1, bus.reEn ? mregs[sa] : 64'd0);
        chk({tag, ".valB"},  bus.val_read2, bus.reEn ? mregs[sb] : 64'd0);
        $display("txn %s op=%02h rArB=%02h re=%0b we=%0b", tag, bus.opcode, bus.rArB, bus.reEn, bus.wrEn);
    endtask

    // One clock edge; the model commits writes with port 2 last so it wins.
    task automatic cycle();
        @(posedge clk);
        if (!reset && bus.wrEn) begin
            if (bus.registernumber1_write != 4'hF) mregs[bus.registernumber1_write] = bus.val_write1;
            if (bus.registernumber2_write != 4'hF) mregs[bus.registernumber2_write] = bus.val_write2;
        end
        @(negedge clk);
    endtask

    task automatic apply(input logic [7:0] op, input logic [7:0] rarb);
        bus.opcode = op;
        bus.rArB   = rarb;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        reset = 1'b1;
        bus.opcode = 8'h10; bus.rArB = 8'hFF; bus.valC = '0;
        bus.reEn = 1'b1; bus.wrEn = 1'b0;
        bus.registernumber1_write = 4'hF; bus.registernumber2_write = 4'hF;
        bus.val_write1 = '0; bus.val_write2 = '0;

        @(negedge clk);
        apply(8'h60, 8'h12);
        check_all("reset_state");
        reset = 1'b0;

        // Decode directed cases
        bus.valC = 64'd80;
        apply(8'h20, 8'hF0); check_all("cmov_raF");
        chk("cmov_raF.dstE_const", 64'(bus.dst_e), 64'd0);
        chk("cmov_raF.err_const", 64'(bus.error), 64'd1);
        apply(8'h24, 8'h4F); check_all("cmov_rbF");
        apply(8'h20, 8'h4F); check_all("cmov_rbF_2");
        apply(8'h60, 8'h4F); check_all("opq_rbF");
        apply(8'h63, 8'h4F); check_all("opq3_rbF");
        apply(8'h63, 8'h45); check_all("opq3_ok");
        chk("opq3_ok.dstE_const", 64'(bus.dst_e), 64'd5);
        apply(8'h64, 8'h45); check_all("opq_ifun4");
        apply(8'h80, 8'h4F); check_all("call");
        apply(8'hB0, 8'h3F); check_all("popq");
        chk("popq.dstM_const", 64'(bus.dst_m), 64'd3);
        apply(8'hC0, 8'h12); check_all("icodeC");
        apply(8'h30, 8'h12); check_all("irmov_raset");
        apply(8'h76, 8'hFF); check_all("jxx_ifun6");
        apply(8'h77, 8'hFF); check_all("jxx_ifun7");

        // Write / read sequence
        bus.wrEn = 1'b1;
        bus.registernumber1_write = 4'd4; bus.val_write1 = 64'h1234;
        bus.registernumber2_write = 4'd3; bus.val_write2 = 64'h55;
        #1; check_all("wr_setup");
        cycle();
        bus.wrEn = 1'b0;
        apply(8'h60, 8'h34); check_all("rd_after_wr");
        chk("rd_after_wr.valA_const", bus.val_read1, 64'h55);
        chk("rd_after_wr.valB_const", bus.val_read2, 64'h1234);
        bus.reEn = 1'b0;
        apply(8'h60, 8'h34); check_all("rd_disabled");
        bus.reEn = 1'b1;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [3:0] ic;
            ic = 4'($urandom_range(0, 15));
            bus.opcode = {ic, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3))};
            bus.rArB   = 8'($urandom);
            bus.valC   = {$urandom, $urandom};
            bus.reEn   = ($urandom_range(0, 7) != 0);
            bus.wrEn   = ($urandom_range(0, 3) != 0);
            bus.registernumber1_write = 4'($urandom);
            bus.registernumber2_write = ($urandom_range(0, 4) == 0) ? bus.registernumber1_write : 4'($urandom);
            bus.val_write1 = {$urandom, $urandom};
            bus.val_write2 = {$urandom, $urandom};
            #1; check_all($sformatf("rand%0d", n));
            cycle();
        end

        // Conflict: port 2 wins, regerr asserted
        bus.reEn = 1'b1; bus.wrEn = 1'b1;
        bus.registernumber1_write = 4'd7; bus.val_write1 = 64'd1;
        bus.registernumber2_write = 4'd7; bus.val_write2 = 64'd2;
        apply(8'h60, 8'h77); check_all("conflict");
        chk("conflict.regerr_const", 64'(bus.regerr), 64'd1);
        cycle();
        bus.wrEn = 1'b0;
        apply(8'h60, 8'h77);
        chk("conflict.r7", bus.val_read1, 64'd2);

        // Mid-cycle asynchronous reset clears immediately and blocks writes
        reset = 1'b1;
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        #1;
        chk("async_reset.valA", bus.val_read1, 64'd0);
        chk("async_reset.valB", bus.val_read2, 64'd0);
        bus.wrEn = 1'b1; bus.val_write1 = 64'hAA; bus.val_write2 = 64'hBB;
        #1;
        chk("reset.regerr", 64'(bus.regerr), 64'd1);
        cycle();
        check_all("reset_blocks_write");
        reset = 1'b0;
        bus.wrEn = 1'b0;
        apply(8'h60, 8'h77); check_all("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/y86_decode_regfile.md
Name: y86_decode_regfile

Overview:
Decode stage of the single-cycle (SEQ) Y86-64 processor, plus the 15-entry, 64-bit register file.
- Splits the opcode and register-specifier bytes.
- Selects source registers (srcA/srcB) and destination registers (dstE/dstM), and flags illegal encodings.
- Reads both sources combinationally.
- Commits up to two write-back results on the clock edge.

Parameters:
- NREG, 15, number of architectural registers (IDs 0-14; ID 15 = 0xF = "none").
- W, 64, data width.
- RSP, 4, stack pointer register ID.

Ports:
- clk  in  1  clock; writes occur on the rising edge.
- reset  in  1  asynchronous, active-high; clears all registers.
- opcode  in  8  [7:4] icode, [3:0] ifun.
- rArB  in  8  [7:4] rA, [3:0] rB.
- valC  in  64  constant word; carried for interface uniformity; does not affect decode outputs.
- reEn  in  1  read enable.
- wrEn  in  1  write enable for both write ports.
- registernumber1_write  in  4  write port 1 register ID (dstE).
- registernumber2_write  in  4  write port 2 register ID (dstM).
- val_write1  in  64  port 1 write data (valE).
- val_write2  in  64  port 2 write data (valM).
- registernumber1  out  4  srcA.
- registernumber2  out  4  srcB.
- dst_e  out  4  decoded dstE.
- dst_m  out  4  decoded dstM.
- val_read1  out  64  valA = R[srcA].
- val_read2  out  64  valB = R[srcB].
- error  out  1  illegal instruction or illegal register specifier.
- regerr  out  1  write-port conflict.

Behaviour:
- Decode is purely combinational (zero latency).
- Default for every case: srcA = srcB = dstE = dstM = 0xF, error = 0.
- Per icode:
  - 0 halt, 1 nop, 7 jXX: no registers.
  - 2 cmovXX: srcA=rA, dstE=rB.
  - 3 irmovq: dstE=rB; error if rA != 0xF.
  - 4 rmmovq: srcA=rA, srcB=rB.
  - 5 mrmovq: srcB=rB, dstM=rA.
  - 6 OPq: srcA=rA, srcB=rB, dstE=rB.
  - 8 call: srcB=RSP, dstE=RSP.
  - 9 ret: srcA=srcB=RSP, dstE=RSP.
  - A pushq: srcA=rA, srcB=RSP, dstE=RSP.
  - B popq: srcA=srcB=RSP, dstE=RSP, dstM=rA.
  - C-F: error=1; all register outputs 0xF.
- Register-specifier errors: error=1 if any rA/rB field that the instruction uses is 0xF.
- Function-code errors: error=1 if ifun > 6 for icodes 2 and 7, ifun > 3 for icode 6, or ifun != 0 for all other icodes.
- On error, register outputs keep their decoded values; downstream stages gate on error.
- Reads are combinational.
  - val_readN = R[id] when reEn=1 and id != 0xF.
  - val_readN = 0 when id == 0xF or reEn=0.
  - A write in cycle N is visible on reads after that edge; there is no write-through bypass.
- Writes occur on posedge clk when wrEn=1. Each port writes only if its ID != 0xF.
- Same-ID conflict (both port IDs equal, not 0xF, wrEn=1):
  - port 2 (valM) wins;
  - regerr=1, combinationally, for as long as the condition holds.
- regerr=0 otherwise.
- Reset (asynchronous, active-high): all registers clear to 0 immediately, and writes are blocked while reset is high. error and regerr depend only on inputs, so reset does not affect them.

Decomposition:
- Shared package y86_pkg:
  - icode constants (I_HALT..I_POPQ);
  - REG_NONE = 4'hF, REG_RSP = 4'h4;
  - widths W and NREG.
- Sub-modules:
  - y86_regfile: storage, two read ports, two write ports, regerr.
  - The decode logic stays as combinational logic in the top module.

Test Plan:
- opcode=0x20, rArB=0xF0, valC=80 -> registernumber1=15, registernumber2=15, dst_e=0, error=1 (rA=0xF); val_read1=val_read2=0.
- opcode=0x24, rArB=0x4F -> registernumber1=4, registernumber2=15, error=1 (rB=0xF). Repeat with opcode=0x20, rArB=0x4F -> same outputs.
- opcode=0x60 and 0x63, rArB=0x4F -> registernumber1=4, registernumber2=15, error=1. opcode=0x63, rArB=0x45 -> registernumber1=4, registernumber2=5, dst_e=5, error=0. opcode=0x64 -> error=1.
- opcode=0x80, rArB=0x4F -> registernumber1=15, registernumber2=4, dst_e=4, error=0. opcode=0xB0, rArB=0x3F -> srcA=srcB=4, dst_e=4, dst_m=3, error=0. opcode=0xC0 -> error=1.
- Write/read sequence:
  - After reset, wrEn=1, registernumber1_write=4, val_write1=0x1234, registernumber2_write=3, val_write2=0x55, one edge.
  - Then opcode=0x60, rArB=0x34 -> val_read1=0x55, val_read2=0x1234.
  - With reEn=0 -> both reads 0.
- Conflict and reset:
  - Both write IDs =7, val_write1=1, val_write2=2, wrEn=1 -> regerr=1; after the edge R[7]=2.
  - Assert reset mid-cycle -> R[7] reads 0 immediately, without waiting for a clock edge.
